// File: rtl/regfile_param.sv
// Parametrised register file with byte-enable writes, asynchronous clear,
// a per-register pending-write scoreboard and a debug tap (max).
// Optional write-through forwarding is compiled in with REGFILE_BYPASS_EN.
module regfile_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DEPTH    = 32,
  parameter bit          ZERO_REG = 1'b1,
  parameter int unsigned TAP_IDX  = 18
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   readreg1,
  input  logic [ADDR_W-1:0]   readreg2,
  input  logic [ADDR_W-1:0]   writereg,
  input  logic [DATA_W-1:0]   writedata,
  input  logic                RegWrite,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                busy_set,
  input  logic [ADDR_W-1:0]   busy_reg,
  output logic [DATA_W-1:0]   readdata1,
  output logic [DATA_W-1:0]   readdata2,
  output logic                busy1,
  output logic                busy2,
  output logic [DATA_W-1:0]   max
);

  localparam int unsigned NBYTES    = DATA_W / 8;
  localparam bit          TAP_VALID = (TAP_IDX < DEPTH);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;

  logic              wr_ok;
  logic              set_ok;
  logic [DATA_W-1:0] rd1_raw;
  logic [DATA_W-1:0] rd2_raw;
  logic              bz1_raw;
  logic              bz2_raw;
  logic [DATA_W-1:0] tap_raw;

  // Address is backed by storage: in range and not the hardwired zero register.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W + 1)'(DEPTH)) && !(ZERO_REG && (a == '0));
  endfunction

  // New bytes where the enable is set, old bytes elsewhere.
  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_data,
                                               input logic [DATA_W-1:0] new_data,
                                               input logic [NBYTES-1:0] be);
    logic [DATA_W-1:0] m;
    m = old_data;
    for (int i = 0; i < int'(NBYTES); i++) begin
      if (be[i]) m[8*i +: 8] = new_data[8*i +: 8];
    end
    return m;
  endfunction

  // Qualify strobes; rst_n gating keeps the forwarding paths quiet during reset.
  always_comb begin
    wr_ok  = rst_n & RegWrite & addr_ok(writereg);
    set_ok = rst_n & busy_set & addr_ok(busy_reg);
  end

  // Storage and scoreboard update; a new issue outranks a retire to the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < int'(DEPTH); r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int r = 0; r < int'(DEPTH); r++) begin
        if (wr_ok && (writereg == ADDR_W'(r))) begin
          regs_q[r] <= merge(regs_q[r], writedata, wr_be);
        end
        if (set_ok && (busy_reg == ADDR_W'(r))) begin
          busy_q[r] <= 1'b1;
        end else if (wr_ok && (writereg == ADDR_W'(r))) begin
          busy_q[r] <= 1'b0;
        end
      end
    end
  end

  // Array read mux; unmatched (out-of-range) addresses fall through to zero.
  always_comb begin
    rd1_raw = '0;
    rd2_raw = '0;
    bz1_raw = 1'b0;
    bz2_raw = 1'b0;
    for (int r = 0; r < int'(DEPTH); r++) begin
      if (readreg1 == ADDR_W'(r)) begin
        rd1_raw = regs_q[r];
        bz1_raw = busy_q[r];
      end
      if (readreg2 == ADDR_W'(r)) begin
        rd2_raw = regs_q[r];
        bz2_raw = busy_q[r];
      end
    end
  end

  generate
    if (TAP_VALID) begin : g_tap
      assign tap_raw = regs_q[TAP_IDX];
    end else begin : g_no_tap
      assign tap_raw = '0;
    end
  endgenerate

`ifdef REGFILE_BYPASS_EN
  logic fwd1;
  logic fwd2;
  logic fwd_tap;

  // Write-through: a same-cycle write to the addressed register is visible at once.
  always_comb begin
    fwd1    = wr_ok && (readreg1 == writereg);
    fwd2    = wr_ok && (readreg2 == writereg);
    fwd_tap = TAP_VALID && wr_ok && ({1'b0, writereg} == (ADDR_W + 1)'(TAP_IDX));
    readdata1 = fwd1 ? merge(rd1_raw, writedata, wr_be) : rd1_raw;
    readdata2 = fwd2 ? merge(rd2_raw, writedata, wr_be) : rd2_raw;
    busy1     = fwd1 ? (set_ok && (busy_reg == readreg1)) : bz1_raw;
    busy2     = fwd2 ? (set_ok && (busy_reg == readreg2)) : bz2_raw;
    max       = fwd_tap ? merge(tap_raw, writedata, wr_be) : tap_raw;
  end
`else
  // Pure array reads; writes become visible after the clock edge.
  always_comb begin
    readdata1 = rd1_raw;
    readdata2 = rd2_raw;
    busy1     = bz1_raw;
    busy2     = bz2_raw;
    max       = tap_raw;
  end
`endif

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: three instances (default, ZERO_REG=0,
// DEPTH=16) share stimulus and are compared against an array-based model.
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  readreg1, readreg2, writereg, busy_reg;
  logic [31:0] writedata;
  logic        RegWrite, busy_set;
  logic [3:0]  wr_be;

  logic [31:0] rd1 [3];
  logic [31:0] rd2 [3];
  logic [31:0] mx  [3];
  logic        bz1 [3];
  logic        bz2 [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_param dut0 (
    .clk(clk), .rst_n(rst_n), .readreg1(readreg1), .readreg2(readreg2),
    .writereg(writereg), .writedata(writedata), .RegWrite(RegWrite), .wr_be(wr_be),
    .busy_set(busy_set), .busy_reg(busy_reg), .readdata1(rd1[0]), .readdata2(rd2[0]),
    .busy1(bz1[0]), .busy2(bz2[0]), .max(mx[0])
  );

  regfile_param #(.ZERO_REG(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .readreg1(readreg1), .readreg2(readreg2),
    .writereg(writereg), .writedata(writedata), .RegWrite(RegWrite), .wr_be(wr_be),
    .busy_set(busy_set), .busy_reg(busy_reg), .readdata1(rd1[1]), .readdata2(rd2[1]),
    .busy1(bz1[1]), .busy2(bz2[1]), .max(mx[1])
  );

  regfile_param #(.DEPTH(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .readreg1(readreg1), .readreg2(readreg2),
    .writereg(writereg), .writedata(writedata), .RegWrite(RegWrite), .wr_be(wr_be),
    .busy_set(busy_set), .busy_reg(busy_reg), .readdata1(rd1[2]), .readdata2(rd2[2]),
    .busy1(bz1[2]), .busy2(bz2[2]), .max(mx[2])
  );

  // Reference model: per-configuration register contents and pending flags.
  int          depth_c [3] = '{32, 32, 16};
  bit          zero_c  [3] = '{1'b1, 1'b0, 1'b1};
  logic [31:0] m   [3][32];
  logic        bsy [3][32];

  function automatic bit backed(int c, int a);
    return (a < depth_c[c]) && !(zero_c[c] && a == 0);
  endfunction

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  function automatic bit fwd_hit(int c, int a);
`ifdef REGFILE_BYPASS_EN
    return rst_n && RegWrite && backed(c, int'(writereg)) && (int'(writereg) == a);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_rd(int c, int a);
    if (!rst_n || !backed(c, a)) return 32'h0;
    if (fwd_hit(c, a)) return merge(m[c][a], writedata, wr_be);
    return m[c][a];
  endfunction

  function automatic logic exp_busy(int c, int a);
    if (!rst_n || !backed(c, a)) return 1'b0;
    if (fwd_hit(c, a)) return busy_set && (int'(busy_reg) == a);
    return bsy[c][a];
  endfunction

  function automatic logic [31:0] exp_max(int c);
    if (18 >= depth_c[c]) return 32'h0;
    return exp_rd(c, 18);
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 3; c++)
      for (int a = 0; a < 32; a++) begin
        m[c][a]   = 32'h0;
        bsy[c][a] = 1'b0;
      end
  endtask

  // Clock-edge effect of the current inputs on the model.
  task automatic model_edge();
    if (!rst_n) return;
    for (int c = 0; c < 3; c++) begin
      if (RegWrite && backed(c, int'(writereg))) begin
        m[c][writereg] = merge(m[c][writereg], writedata, wr_be);
        if (!(busy_set && busy_reg == writereg)) bsy[c][writereg] = 1'b0;
      end
      if (busy_set && backed(c, int'(busy_reg))) bsy[c][busy_reg] = 1'b1;
    end
  endtask

  task automatic check(input string name, input int c, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d @%0t: got %h want %h", name, c, $time, got, exp);
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < 3; c++) begin
      check("readdata1", c, rd1[c], exp_rd(c, int'(readreg1)));
      check("readdata2", c, rd2[c], exp_rd(c, int'(readreg2)));
      check("busy1", c, {31'b0, bz1[c]}, {31'b0, exp_busy(c, int'(readreg1))});
      check("busy2", c, {31'b0, bz2[c]}, {31'b0, exp_busy(c, int'(readreg2))});
      check("max", c, mx[c], exp_max(c));
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    RegWrite = 1'b0; busy_set = 1'b0; wr_be = 4'h0; writedata = 32'h0;
    writereg = 5'd0; busy_reg = 5'd0; readreg1 = 5'd0; readreg2 = 5'd0;
  endtask

  task automatic random_cycle();
    writereg  = 5'($urandom_range(0, 31));
    writedata = $urandom;
    wr_be     = 4'($urandom);
    RegWrite  = ($urandom_range(0, 2) != 0);
    busy_set  = ($urandom_range(0, 2) == 0);
    busy_reg  = ($urandom_range(0, 3) == 0) ? writereg : 5'($urandom_range(0, 31));
    readreg1  = ($urandom_range(0, 3) == 0) ? writereg : 5'($urandom_range(0, 31));
    readreg2  = ($urandom_range(0, 4) == 0) ? 5'd18 : 5'($urandom_range(0, 31));
    #3;
    check_all();
    advance();
  endtask

  typedef struct {
    logic [4:0]  rr1, rr2, wr;
    logic [31:0] wd;
    logic        we;
    logic [3:0]  be;
    logic        bs;
    logic [4:0]  breg;
    logic [31:0] e_rd1, e_rd2;
    logic        e_b1, e_b2;
    logic [31:0] e_max;
    bit          chk_max;
  } vec_t;

  vec_t tbl [9];

  initial begin
    // Rows never read the register being written in the same cycle, so the
    // expected values hold with or without forwarding (except a tap write).
    tbl[0] = '{5'd1, 5'd2, 5'd7,  32'h11223344, 1'b1, 4'hF, 1'b0, 5'd0,
               32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1};
    tbl[1] = '{5'd1, 5'd2, 5'd7,  32'hAABBCCDD, 1'b1, 4'h5, 1'b0, 5'd0,
               32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1};
    tbl[2] = '{5'd7, 5'd9, 5'd18, 32'h00000042, 1'b1, 4'hF, 1'b1, 5'd9,
               32'h11BB33DD, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    tbl[3] = '{5'd9, 5'd7, 5'd0,  32'h0,        1'b0, 4'hF, 1'b0, 5'd0,
               32'h0, 32'h11BB33DD, 1'b1, 1'b0, 32'h42, 1'b1};
    tbl[4] = '{5'd18, 5'd7, 5'd9, 32'h00000005, 1'b1, 4'hF, 1'b1, 5'd9,
               32'h42, 32'h11BB33DD, 1'b0, 1'b0, 32'h42, 1'b1};
    tbl[5] = '{5'd9, 5'd18, 5'd0, 32'h0,        1'b0, 4'h0, 1'b0, 5'd0,
               32'h5, 32'h42, 1'b1, 1'b0, 32'h42, 1'b1};
    tbl[6] = '{5'd7, 5'd1, 5'd9,  32'hFFFFFFFF, 1'b1, 4'h0, 1'b0, 5'd0,
               32'h11BB33DD, 32'h0, 1'b0, 1'b0, 32'h42, 1'b1};
    tbl[7] = '{5'd9, 5'd0, 5'd0,  32'hFFFFFFFF, 1'b1, 4'hF, 1'b1, 5'd0,
               32'h5, 32'h0, 1'b0, 1'b0, 32'h42, 1'b1};
    tbl[8] = '{5'd0, 5'd0, 5'd0,  32'h0,        1'b0, 4'h0, 1'b0, 5'd0,
               32'h0, 32'h0, 1'b0, 1'b0, 32'h42, 1'b1};

    idle_inputs();
    rst_n = 1'b0;
    model_clear();
    #2;
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed table on the default instance, with the model checking all three.
    for (int i = 0; i < 9; i++) begin
      readreg1 = tbl[i].rr1; readreg2 = tbl[i].rr2; writereg = tbl[i].wr;
      writedata = tbl[i].wd; RegWrite = tbl[i].we; wr_be = tbl[i].be;
      busy_set = tbl[i].bs; busy_reg = tbl[i].breg;
      #3;
      check("tbl_rd1", i, rd1[0], tbl[i].e_rd1);
      check("tbl_rd2", i, rd2[0], tbl[i].e_rd2);
      check("tbl_b1", i, {31'b0, bz1[0]}, {31'b0, tbl[i].e_b1});
      check("tbl_b2", i, {31'b0, bz2[0]}, {31'b0, tbl[i].e_b2});
      if (tbl[i].chk_max) check("tbl_max", i, mx[0], tbl[i].e_max);
      check_all();
      advance();
    end

    // ZERO_REG=0 keeps r0 as an ordinary register (written and marked in row 7).
    idle_inputs();
    #3;
    check("r0_ordinary", 1, rd2[1], 32'hFFFFFFFF);
    check("r0_busy", 1, {31'b0, bz2[1]}, 32'h1);
    check("r0_zero", 0, rd2[0], 32'h0);
    advance();

    // DEPTH=16: address 20 is ignored on write and reads 0; no aliasing onto r4.
    writereg = 5'd20; writedata = 32'h12345678; wr_be = 4'hF; RegWrite = 1'b1;
    busy_set = 1'b1; busy_reg = 5'd20;
    #3;
    check_all();
    advance();
    idle_inputs();
    readreg1 = 5'd20; readreg2 = 5'd4;
    #3;
    check("oor_read", 2, rd1[2], 32'h0);
    check("oor_busy", 2, {31'b0, bz1[2]}, 32'h0);
    check("no_alias", 2, rd2[2], 32'h0);
    check_all();
    advance();

    // Same-cycle write and read of r3.
    writereg = 5'd3; writedata = 32'hCAFEF00D; wr_be = 4'hF; RegWrite = 1'b1;
    readreg1 = 5'd3;
    #3;
`ifdef REGFILE_BYPASS_EN
    check("bypass", 0, rd1[0], 32'hCAFEF00D);
`else
    check("no_bypass", 0, rd1[0], 32'h0);
`endif
    check_all();
    advance();
    RegWrite = 1'b0;
    #3;
    check("after_write", 0, rd1[0], 32'hCAFEF00D);
    advance();

    for (int i = 0; i < 400; i++) random_cycle();

    // Asynchronous clear mid-cycle, with a write still being driven.
    idle_inputs();
    writereg = 5'd5; writedata = 32'hDEADBEEF; wr_be = 4'hF; RegWrite = 1'b1;
    busy_set = 1'b1; busy_reg = 5'd9;
    readreg1 = 5'd5; readreg2 = 5'd9;
    #3;
    check_all();
    advance();
    #2;
    rst_n = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      check("rst_rd1", c, rd1[c], 32'h0);
      check("rst_b2", c, {31'b0, bz2[c]}, 32'h0);
      check("rst_max", c, mx[c], 32'h0);
    end
    model_clear();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    idle_inputs();
    rst_n = 1'b1;

    for (int i = 0; i < 100; i++) random_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the single-cycle 32x32 register file in the datapath.
- Generalised in data width, depth, hardwired-zero policy and debug-tap index.
- Adds byte-enable writes, async active-low clear, and a per-register pending-write scoreboard so the controller can detect read-after-write hazards.
- Sits between decode (read/issue) and writeback (write/retire).

Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8.
- ADDR_W, 5, register address width.
- DEPTH, 32, number of registers; must be ≤ 2**ADDR_W.
- ZERO_REG, 1, 1: register 0 reads 0 and ignores writes; 0: register 0 is ordinary.
- TAP_IDX, 18, index of the register driven onto the max tap output.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- readreg1  input  ADDR_W  read port 1 address.
- readreg2  input  ADDR_W  read port 2 address.
- writereg  input  ADDR_W  write address.
- writedata  input  DATA_W  write data.
- RegWrite  input  1  write strobe.
- wr_be  input  DATA_W/8  byte enables for the write; bit i covers bits [8i+7:8i].
- busy_set  input  1  mark busy_reg as pending (issue of an instruction writing it).
- busy_reg  input  ADDR_W  register to mark pending.
- readdata1  output  DATA_W  combinational read of readreg1.
- readdata2  output  DATA_W  combinational read of readreg2.
- busy1  output  1  pending flag of readreg1.
- busy2  output  1  pending flag of readreg2.
- max  output  DATA_W  continuous view of register TAP_IDX.

Behaviour:
- Reset:
  - rst_n low clears all DEPTH registers and all pending flags immediately, without waiting for clk.
  - During reset, every read output, busy1, busy2 and max read 0.
  - Writes and busy_set are ignored while rst_n is low.
  - Deassertion is taken synchronously by the integrator; the block does no internal synchronisation.
- Write:
  - On posedge clk with RegWrite=1 and writereg<DEPTH, each byte i with wr_be[i]=1 takes writedata's byte i.
  - Bytes with wr_be[i]=0 keep their old value.
  - wr_be all-zero means no data change, but the pending flag is still cleared.
- Zero register:
  - With ZERO_REG=1, writes to address 0 are discarded.
  - Address 0 always reads 0, and its busy flag is always 0.
  - busy_set to address 0 has no effect.
- Out-of-range addresses (≥DEPTH):
  - Reads return 0 and busy reads 0.
  - Writes and busy_set are ignored.
- Read: combinational from the array. Latency 0 for reads; 1 cycle for writes to become visible (except under the optional feature).
- Scoreboard, one flag per register; on posedge clk, in priority order:
  - Rule 1: busy_set to register r sets flag r.
  - Rule 2: if not set by rule 1, a RegWrite to r clears flag r.
  - Simultaneous busy_set and RegWrite to the same r: flag ends set, because the new issue supersedes the older retire.
  - busy_set and RegWrite to different registers are independent.
- Tap:
  - max equals register TAP_IDX with the same combinational path as the read ports.
  - If TAP_IDX ≥ DEPTH, max is tied to 0.
- Simultaneous read and write of the same address in one cycle: readdata returns the pre-edge stored value (no forwarding), unless the optional feature is compiled in.
- Both read ports addressing the same register return identical data.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- When defined:
  - Write-through forwarding applies when RegWrite=1, the address is valid and not a discarded zero-register write, and readregN equals writereg.
  - readdataN then returns the merged value: new bytes where wr_be=1, stored bytes elsewhere.
  - busyN for that register reads 0, unless busy_set targets the same register in that cycle.
  - max is forwarded the same way.
- When undefined: pure array reads; the new value is visible from the cycle after the edge.

Test Plan:
- Reset clear: write 0xDEADBEEF to r5, then pulse rst_n low mid-cycle. Required: readdata1(r5)=0 immediately, before any clk edge; busy flags all 0.
- Byte enables: r7=0x11223344, then write 0xAABBCCDD with wr_be=4'b0101. Required: r7 reads 0x11BB33DD.
- Zero register (ZERO_REG=1): write 0xFFFFFFFF to r0 and busy_set r0. Required: readdata2(r0)=0 and busy2=0. Repeat with ZERO_REG=0. Required: r0 reads 0xFFFFFFFF.
- Scoreboard:
  - busy_set r9 gives busy1=1 the next cycle.
  - A RegWrite to r9 then clears it.
  - Same-cycle busy_set and RegWrite on r9 leaves busy1=1.
- Tap and range:
  - Write 0x00000042 to r18. Required: max=0x42.
  - With DEPTH=16, read address 20. Required: readdata=0.
  - With DEPTH=16, write to address 20. Required: no register changes.
- Bypass: same-cycle write 0xCAFEF00D to r3 and read r3 on port 1. Required: readdata1=0xCAFEF00D with REGFILE_BYPASS_EN defined; old value without it.
